// File: rtl/gpu_bus_pkg.sv
// Shared definitions for the scheduler->core frame bus: header field
// positions, receiver FSM states and error bit positions.
package gpu_bus_pkg;

    // Header frame (F0) field layout
    localparam int HDR_NBLK_LSB    = 0;
    localparam int HDR_NBLK_W      = 6;
    localparam int HDR_HOLD_BIT    = 6;
    localparam int HDR_ALLFREE_BIT = 7;

    // Bit positions inside the sticky err vector {overflow, collision, mask_mismatch}
    localparam int ERR_MASK_BIT = 0;
    localparam int ERR_COLL_BIT = 1;
    localparam int ERR_OVF_BIT  = 2;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_HDR     = 3'd0,
        ST_MASK1   = 3'd1,
        ST_MASK2   = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_LAUNCH  = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_payload_counter.sv
// Payload frame down-counter and instruction memory address generator.
// The address stops advancing once it reaches IMEM_DEPTH and o_ovf is
// raised; the frame counter keeps running so the stream stays aligned.
module rx_payload_counter #(
    parameter int IMEM_DEPTH = 1024,
    parameter int CNT_W      = 11
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_load,
    input  logic [CNT_W-1:0]              i_load_val,
    input  logic                          i_dec,
    output logic                          o_last,
    output logic [$clog2(IMEM_DEPTH)-1:0] o_addr,
    output logic                          o_ovf
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_addr;
    logic             w_ovf;

    assign w_ovf  = (r_addr >= CNT_W'(IMEM_DEPTH));
    assign o_ovf  = w_ovf;
    assign o_last = (r_cnt == CNT_W'(1));
    assign o_addr = r_addr[AW-1:0];

    // Reload at the mask-copy frame, then count payload frames down and addresses up
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_addr <= '0;
        end else if (i_load) begin
            r_cnt  <= i_load_val;
            r_addr <= '0;
        end else if (i_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (!w_ovf) begin
                r_addr <= r_addr + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/core_frame_receiver.sv
// Per-core receive end of the scheduler->core frame bus. Parses task
// headers and core masks, loads selected payloads into local instruction
// memory and launches the task.
// Optional build macro RX_MASK_CHECK_EN: compare the mask copy (F2) with
// the mask (F1); a mismatch sets err[0] and skips the payload.
module core_frame_receiver
    import gpu_bus_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int CORE_NUM   = 16,
    parameter int FRAME_SIZE = 16,
    parameter int INSTR_SIZE = 16,
    parameter int BLOCK_SIZE = 16,
    parameter int IMEM_DEPTH = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FRAME_SIZE-1:0]         frame_data,
    input  logic                          frame_valid,
    input  logic                          pause,
    output logic                          core_reading,
    output logic                          core_ready,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [INSTR_SIZE-1:0]         imem_wdata,
    output logic                          task_start,
    output logic [$clog2(IMEM_DEPTH):0]   task_len,
    output logic [1:0]                    task_flags,
    input  logic                          task_done,
    output logic [2:0]                    err
);

    localparam int AW    = $clog2(IMEM_DEPTH);
    localparam int LW    = AW + 1;
    localparam int NW    = HDR_NBLK_W + $clog2(BLOCK_SIZE);
    localparam int CNT_W = ((NW > AW) ? NW : AW) + 1;

    rx_state_e               r_state;
    logic [HDR_NBLK_W-1:0]   r_nblk;
    logic [1:0]              r_flags;
    logic                    r_sel;
    logic                    r_busy;
    logic                    r_we;
    logic [AW-1:0]           r_addr;
    logic [INSTR_SIZE-1:0]   r_wdata;
    logic                    r_start;
    logic [LW-1:0]           r_len;
    logic [1:0]              r_tflags;
    logic [2:0]              r_err;

    logic                    w_xfer;
    logic                    w_own;
    logic                    w_mask_ok;
    logic                    w_busy_eff;
    logic                    w_sel_raw;
    logic                    w_coll;
    logic                    w_sel;
    logic                    w_load;
    logic                    w_dec;
    logic                    w_last;
    logic                    w_ovf;
    logic                    w_launch;
    logic [AW-1:0]           w_cnt_addr;
    logic [CNT_W-1:0]        w_load_val;

`ifdef RX_MASK_CHECK_EN
    logic [CORE_NUM-1:0]     r_mask;
    assign w_own     = r_mask[CORE_ID];
    assign w_mask_ok = (frame_data[CORE_NUM-1:0] == r_mask);
`else
    logic [0:0]              r_mask;
    assign w_own     = r_mask[0];
    assign w_mask_ok = 1'b1;
`endif

    assign core_reading = reset & ~pause;
    assign core_ready   = reset & ~r_busy;
    assign w_xfer       = frame_valid & core_reading;

    // task_done arriving with the mask copy frees the core for this task
    assign w_busy_eff = r_busy & ~task_done;
    assign w_sel_raw  = w_own & w_mask_ok;
    assign w_coll     = w_sel_raw & w_busy_eff;
    assign w_sel      = w_sel_raw & ~w_busy_eff;

    assign w_load     = w_xfer && (r_state == ST_MASK2);
    assign w_dec      = w_xfer && (r_state == ST_PAYLOAD);
    assign w_load_val = CNT_W'(r_nblk) * CNT_W'(BLOCK_SIZE);
    assign w_launch   = (w_load && (r_nblk == '0) && w_sel) || (w_dec && w_last && r_sel);

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign task_start = r_start;
    assign task_len   = r_len;
    assign task_flags = r_tflags;
    assign err        = r_err;

    rx_payload_counter #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .CNT_W      (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_last     (w_last),
        .o_addr     (w_cnt_addr),
        .o_ovf      (w_ovf)
    );

    // Frame parsing FSM, busy tracking, registered imem writes and launch outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_HDR;
            r_nblk   <= '0;
            r_flags  <= '0;
            r_mask   <= '0;
            r_sel    <= 1'b0;
            r_busy   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_start  <= 1'b0;
            r_len    <= '0;
            r_tflags <= '0;
            r_err    <= '0;
        end else begin
            r_we    <= 1'b0;
            r_start <= w_launch;
            if (w_launch) begin
                r_len    <= w_load_val[LW-1:0];
                r_tflags <= r_flags;
                r_busy   <= 1'b1;
            end else if (task_done) begin
                r_busy <= 1'b0;
            end

            case (r_state)
                ST_HDR, ST_LAUNCH: begin
                    // LAUNCH consumes no frame of its own, so a frame here is the next header
                    if (w_xfer) begin
                        r_nblk  <= frame_data[HDR_NBLK_LSB +: HDR_NBLK_W];
                        r_flags <= {frame_data[HDR_ALLFREE_BIT], frame_data[HDR_HOLD_BIT]};
                        r_state <= ST_MASK1;
                    end else begin
                        r_state <= ST_HDR;
                    end
                end
                ST_MASK1: begin
                    if (w_xfer) begin
`ifdef RX_MASK_CHECK_EN
                        r_mask <= frame_data[CORE_NUM-1:0];
`else
                        r_mask <= frame_data[CORE_ID];
`endif
                        r_state <= ST_MASK2;
                    end
                end
                ST_MASK2: begin
                    if (w_xfer) begin
                        r_sel <= w_sel;
                        if (w_coll) begin
                            r_err[ERR_COLL_BIT] <= 1'b1;
                        end
`ifdef RX_MASK_CHECK_EN
                        if (!w_mask_ok) begin
                            r_err[ERR_MASK_BIT] <= 1'b1;
                        end
`endif
                        if (r_nblk != '0) begin
                            r_state <= ST_PAYLOAD;
                        end else if (w_sel) begin
                            r_state <= ST_LAUNCH;
                        end else begin
                            r_state <= ST_HDR;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_xfer) begin
                        if (r_sel) begin
                            if (w_ovf) begin
                                r_err[ERR_OVF_BIT] <= 1'b1;
                            end else begin
                                r_we    <= 1'b1;
                                r_addr  <= w_cnt_addr;
                                r_wdata <= frame_data;
                            end
                        end
                        if (w_last) begin
                            if (r_sel) begin
                                r_state <= ST_LAUNCH;
                            end else begin
                                r_state <= ST_HDR;
                            end
                        end
                    end
                end
                default: r_state <= ST_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_core_frame_receiver.sv
// Directed bench for core_frame_receiver: three receivers (core 0, core 4,
// core 0 with a 128-word memory) each on their own bus.
module tb_core_frame_receiver;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0][15:0]  fd;
    logic [2:0]        fv, ps, td, pm;
    logic [2:0]        cr, rdy, we, ts;
    logic [2:0][2:0]   er;
    logic [2:0][1:0]   tf;
    logic [2:0][9:0]   ad;
    logic [2:0][10:0]  ln;
    logic [2:0][15:0]  wd;

    logic [25:0] q0[$];
    logic [25:0] q1[$];
    logic [25:0] q2[$];
    int          ns[3];
    logic [15:0] pay[1024];
    int          total = 0;
    int          bad = 0;
    int          pcnt = 0;

    always #5 clk = ~clk;

    assign ad[2][9:7]  = 3'b0;
    assign ln[2][10:8] = 3'b0;

    core_frame_receiver #(.CORE_ID(0), .IMEM_DEPTH(1024)) u_a (
        .clk(clk), .reset(reset), .frame_data(fd[0]), .frame_valid(fv[0]), .pause(ps[0]),
        .core_reading(cr[0]), .core_ready(rdy[0]), .imem_we(we[0]), .imem_addr(ad[0]),
        .imem_wdata(wd[0]), .task_start(ts[0]), .task_len(ln[0]), .task_flags(tf[0]),
        .task_done(td[0]), .err(er[0]));

    core_frame_receiver #(.CORE_ID(4), .IMEM_DEPTH(1024)) u_b (
        .clk(clk), .reset(reset), .frame_data(fd[1]), .frame_valid(fv[1]), .pause(ps[1]),
        .core_reading(cr[1]), .core_ready(rdy[1]), .imem_we(we[1]), .imem_addr(ad[1]),
        .imem_wdata(wd[1]), .task_start(ts[1]), .task_len(ln[1]), .task_flags(tf[1]),
        .task_done(td[1]), .err(er[1]));

    core_frame_receiver #(.CORE_ID(0), .IMEM_DEPTH(128)) u_c (
        .clk(clk), .reset(reset), .frame_data(fd[2]), .frame_valid(fv[2]), .pause(ps[2]),
        .core_reading(cr[2]), .core_ready(rdy[2]), .imem_we(we[2]), .imem_addr(ad[2][6:0]),
        .imem_wdata(wd[2]), .task_start(ts[2]), .task_len(ln[2][7:0]), .task_flags(tf[2]),
        .task_done(td[2]), .err(er[2]));

    // Write and launch logger, sampled on the falling edge
    initial begin
        ns[0] = 0; ns[1] = 0; ns[2] = 0;
        forever begin
            @(negedge clk);
            if (we[0]) q0.push_back({ad[0], wd[0]});
            if (we[1]) q1.push_back({ad[1], wd[1]});
            if (we[2]) q2.push_back({ad[2], wd[2]});
            for (int i = 0; i < 3; i++) if (ts[i]) ns[i]++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic [15:0] f);
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            fd[d] = f;
            fv[d] = 1'b1;
            ps[d] = pm[d] ? (((pcnt / 3) % 2) == 1) : 1'b0;
            pcnt++;
            #1;
            if (cr[d]) break;
            guard++;
            if (guard >= 50) begin
                chk("send_timeout", 0, 1);
                fv[d] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        fv[d] = 1'b0;
    endtask

    task automatic xfer_task(input int d, input logic [15:0] h, input logic [15:0] m1,
                             input logic [15:0] m2, input int n);
        send(d, h);
        send(d, m1);
        send(d, m2);
        for (int i = 0; i < n; i++) begin
            pay[i] = 16'($urandom);
            send(d, pay[i]);
        end
    endtask

    task automatic pulse_done(input int d);
        @(negedge clk);
        td[d] = 1'b1;
        @(posedge clk);
        #1;
        td[d] = 1'b0;
    endtask

    task automatic chk_writes(input string tag, input int d, input int base, input int n);
        int sz, nb;
        logic [25:0] e;
        sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        chk({tag, "_count"}, sz - base, n);
        nb = 0;
        for (int i = 0; i < n; i++) begin
            if (base + i < sz) begin
                e = (d == 0) ? q0[base + i] : (d == 1) ? q1[base + i] : q2[base + i];
                if (e !== {10'(i), pay[i]}) nb++;
            end
        end
        chk({tag, "_data"}, nb, 0);
    endtask

    initial begin
        int b0, b1, b2, n0, n1, n2;
        reset = 1'b0;
        fd = '0; fv = '0; ps = '0; td = '0; pm = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reading", cr[0], 0);
        chk("rst_ready", rdy[0], 0);
        chk("rst_we", we[0], 0);
        chk("rst_start", ts[0], 0);
        chk("rst_err", er[0], 0);
        chk("rst_len", ln[0], 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle_ready", rdy[0], 1);
        chk("idle_reading", cr[0], 1);

        // core 0 selected, 3 blocks
        b0 = q0.size();
        xfer_task(0, 16'h0003, 16'h000f, 16'h000f, 48);
        chk("a_start", ts[0], 1);
        chk("a_ready_low", rdy[0], 0);
        chk("a_len", ln[0], 48);
        chk("a_flags", tf[0], 0);
        @(posedge clk);
        #1;
        chk("a_start_pulse", ts[0], 0);
        repeat (2) @(posedge clk);
        #1;
        chk_writes("a_wr", 0, b0, 48);
        chk("a_nstart", ns[0], 1);

        // core 4 not selected, then next header back to back
        xfer_task(1, 16'h0003, 16'h000f, 16'h000f, 48);
        chk("b_skip_ready", rdy[1], 1);
        chk("b_skip_start", ns[1], 0);
        xfer_task(1, 16'h0001, 16'h0010, 16'h0010, 16);
        chk("b_next_start", ts[1], 1);
        chk("b_next_len", ln[1], 16);
        repeat (2) @(posedge clk);
        #1;
        chk_writes("b_wr", 1, 0, 16);

        // collision on busy core 0
        b0 = q0.size();
        n0 = ns[0];
        xfer_task(0, 16'h0001, 16'h000f, 16'h000f, 16);
        repeat (2) @(posedge clk);
        #1;
        chk("coll_err", er[0], 3'b010);
        chk("coll_nowr", q0.size() - b0, 0);
        chk("coll_nolaunch", ns[0] - n0, 0);
        pulse_done(0);
        chk("done_ready", rdy[0], 1);
        b0 = q0.size();
        xfer_task(0, 16'h0001, 16'h000f, 16'h000f, 16);
        chk("resend_start", ts[0], 1);
        chk("resend_len", ln[0], 16);
        repeat (2) @(posedge clk);
        #1;
        chk_writes("resend_wr", 0, b0, 16);

        // hold flag, then memory overflow on 128-word receiver
        b2 = q2.size();
        xfer_task(2, 16'h0043, 16'h0001, 16'h0001, 48);
        chk("hold_flags", tf[2], 1);
        chk("hold_len", ln[2], 48);
        repeat (2) @(posedge clk);
        #1;
        chk_writes("hold_wr", 2, b2, 48);
        pulse_done(2);
        b2 = q2.size();
        n2 = ns[2];
        xfer_task(2, 16'h008f, 16'h0001, 16'h0001, 240);
        chk("ovf_start", ts[2], 1);
        chk("ovf_len", ln[2], 240);
        chk("ovf_flags", tf[2], 2);
        repeat (2) @(posedge clk);
        #1;
        chk("ovf_err", er[2], 3'b100);
        chk_writes("ovf_wr", 2, b2, 128);
        chk("ovf_nstart", ns[2] - n2, 1);
        pulse_done(2);
        b2 = q2.size();
        xfer_task(2, 16'h0001, 16'h0001, 16'h0001, 16);
        chk("after_ovf_start", ts[2], 1);
        repeat (2) @(posedge clk);
        #1;
        chk_writes("after_ovf_wr", 2, b2, 16);

        // pause toggling during payload on core 4
        pulse_done(1);
        pm[1] = 1'b1;
        b1 = q1.size();
        n1 = ns[1];
        xfer_task(1, 16'h0002, 16'h0010, 16'h0010, 32);
        pm[1] = 1'b0;
        ps[1] = 1'b0;
        chk("pause_start", ts[1], 1);
        chk("pause_len", ln[1], 32);
        repeat (2) @(posedge clk);
        #1;
        chk_writes("pause_wr", 1, b1, 32);
        chk("pause_nstart", ns[1] - n1, 1);

        // reset in the middle of a payload on core 0
        pulse_done(0);
        send(0, 16'h0002);
        send(0, 16'h0001);
        send(0, 16'h0001);
        for (int i = 0; i < 20; i++) send(0, 16'($urandom));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_we", we[0], 0);
        chk("mid_rst_reading", cr[0], 0);
        chk("mid_rst_ready", rdy[0], 0);
        chk("mid_rst_len", ln[0], 0);
        chk("mid_rst_err", er[0], 0);
        chk("mid_rst_addr", ad[0], 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        b0 = q0.size();
        xfer_task(0, 16'h0001, 16'h0001, 16'h0001, 16);
        chk("post_rst_start", ts[0], 1);
        chk("post_rst_len", ln[0], 16);
        repeat (2) @(posedge clk);
        #1;
        chk_writes("post_rst_wr", 0, b0, 16);

        // mask copy differs from mask
        pulse_done(0);
        b0 = q0.size();
        n0 = ns[0];
        xfer_task(0, 16'h0001, 16'h000f, 16'h00f0, 16);
        repeat (2) @(posedge clk);
        #1;
`ifdef RX_MASK_CHECK_EN
        chk("mchk_err", er[0], 3'b001);
        chk("mchk_nowr", q0.size() - b0, 0);
        chk("mchk_nolaunch", ns[0] - n0, 0);
`else
        chk("mchk_err", er[0], 3'b000);
        chk_writes("mchk_wr", 0, b0, 16);
        chk("mchk_launch", ns[0] - n0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/core_frame_receiver.md
Name: core_frame_receiver

Overview:
- Per-core receive end of the scheduler→core frame bus.
- Every core snoops the shared bus and parses task headers and core masks.
- When its own mask bit is set, it writes the task's instruction payload into the local instruction memory and launches the task.
- It drives the core_reading and core_ready signals that the scheduler consumes.

Parameters:
- CORE_ID, 0: index of this core's bit in the core mask.
- CORE_NUM, 16: mask width; must be ≤ FRAME_SIZE.
- FRAME_SIZE, 16: bus frame width.
- INSTR_SIZE, 16: instruction width; equals FRAME_SIZE.
- BLOCK_SIZE, 16: instructions per payload block.
- IMEM_DEPTH, 1024: local instruction memory depth in words.

Ports:
- clk  in  1  clock
- reset  in  1  one clock; reset is synchronous and active-low
- frame_data  in  FRAME_SIZE  bus frame
- frame_valid  in  1  scheduler is driving a frame (frame_being_sent)
- pause  in  1  core-side stall; forces core_reading low
- core_reading  out  1  frame accepted this cycle when frame_valid is also high
- core_ready  out  1  core idle, may be assigned a task
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  $clog2(IMEM_DEPTH)  write address
- imem_wdata  out  INSTR_SIZE  write data
- task_start  out  1  one-cycle launch pulse
- task_len  out  $clog2(IMEM_DEPTH)+1  instructions loaded
- task_flags  out  2  header bits [7:6]
- task_done  in  1  core finished its task (pulse)
- err  out  3  sticky: {overflow, collision, mask_mismatch}

Behaviour:
- Transfer: a frame is transferred when frame_valid && core_reading. core_reading = !pause while out of reset; it is 0 during reset.
- Frame stream per task:
  - F0 header: [5:0] = block count N; [6] = hold flag; [7] = all-free flag; [15:8] reserved and ignored.
  - F1: core mask.
  - F2: mask copy.
  - Then N*BLOCK_SIZE payload frames.
- FSM states: HDR → MASK1 → MASK2 → PAYLOAD → LAUNCH → HDR.
  - HDR: latch N and flags on transfer.
  - MASK1: latch mask.
  - MASK2: compute sel = mask[CORE_ID].
    - If N==0, go to LAUNCH when sel, else go to HDR.
  - PAYLOAD: a down-counter of payload frames is decremented on each transfer. Leave PAYLOAD after the transfer that brings the counter to 0.
    - Next state is LAUNCH if sel, else HDR.
  - LAUNCH: one cycle, no frame is consumed. core_reading stays high but transfers in LAUNCH are treated as HDR, so the FSM is ready for back-to-back tasks.
- Non-selected cores count payload frames and discard them (no imem_we).
- Writes to instruction memory:
  - Registered: imem_we/addr/wdata are valid the cycle after the payload transfer.
  - Addresses run 0,1,2,… per task.
  - If the address would reach IMEM_DEPTH, suppress the write and set err[2]; counting continues so the frame stream stays aligned.
- Launch:
  - task_start is high in the cycle after the last payload transfer (or after the F2 transfer when N==0).
  - task_len = N*BLOCK_SIZE, held until the next launch; task_flags likewise.
  - core_ready falls in the same cycle that task_start rises.
- busy: set at launch, cleared by task_done. core_ready = !busy.
  - task_done in the same cycle as launch: launch wins, busy stays 1.
- Collision: sel && busy at the F2 transfer (task_done in that cycle counts as free):
  - set err[1];
  - force sel = 0, so the payload is skipped and there is no launch.
- Reset: all outputs 0, err cleared, busy=0, FSM to HDR. Reset mid-task discards the partial load. Resync relies on the scheduler also being reset.
- pause mid-payload only stalls; counts and addresses are preserved.

Optional Feature:
- RX_MASK_CHECK_EN defined:
  - F2 is compared with F1.
  - On mismatch: set err[0], sel=0, payload skipped.
- Undefined: F2 is consumed and ignored; err[0] is tied to 0.

Decomposition:
- Package gpu_bus_pkg holds:
  - header field constants (HDR_NBLK_LSB=0, HDR_NBLK_W=6, HDR_HOLD_BIT=6, HDR_ALLFREE_BIT=7);
  - the FSM state enum;
  - error bit indices.
- One sub-module, rx_payload_counter: payload down-counter plus imem address generator with overflow detect.
- FSM, busy tracking and handshake stay in core_frame_receiver.

Test Plan:
- CORE_ID=0; frames 0x0003, 0x000f, 0x000f, then 48 random frames, pause=0 → 48 writes to addr 0..47 with matching data; task_start one cycle after frame 50; task_len=48; core_ready 1→0.
- CORE_ID=4, same stream → no imem_we, no task_start, core_ready stays 1; FSM accepts the next header immediately.
- CORE_ID=0 busy, second task with mask 0x000f → err[1]=1, no writes, no launch; pulse task_done, resend the task → loads normally.
- Header 0x0043 (N=3, hold flag) → task_flags=2'b01. Header 0x008f, N=15, IMEM_DEPTH=128 → writes stop at addr 127, err[2]=1, FSM returns to HDR after 240 payload frames.
- pause toggled every 3 cycles during payload → addresses contiguous with no gaps or duplicates; reset asserted at payload frame 20 → outputs 0, next frame parsed as header.
- RX_MASK_CHECK_EN defined, F1=0x000f, F2=0x00f0 → err[0]=1, no launch. Undefined, same stream → normal load.
